gshare_pre: RTL and testbench
=============================

Name: gshare_pre

Overview:
- Parametrised successor to the 2-bit bimodal branch predictor in the fetch/decode path.
- Uses a pattern history table (PHT) of CNT_W-bit saturating counters. Each counter is indexed by instruction address bits XOR a global history register (GHR).
- Provides a combinational prediction for the instruction at fetch (Iadd/Idata). Trains on the resolved branch (Badd/Bdata/result).
- Adds an init sweep FSM, a defined non-branch output, and optional accuracy statistics.

Parameters:
- IDX_W, 7, PHT index width; ENTRY = 2**IDX_W entries.
- CNT_W, 2, saturating counter width (>=2).
- HIST_W, 6, GHR length; must satisfy 1 <= HIST_W <= IDX_W.
- INIT_VAL, 2**(CNT_W-1)-1, counter value written during init (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Iadd  in  32  fetch-stage instruction address.
- Idata  in  32  fetch-stage instruction word.
- Badd  in  32  resolving branch address.
- Bdata  in  32  resolving branch instruction word.
- result  in  1  resolved direction: 1 taken, 0 not taken.
- if_id_write  in  1  update enable: 0 = pipeline stalled, no training.
- predict  out  1  predicted direction.
- pred_valid  out  1  1 when Idata is a branch and the block is ready.
- ready  out  1  0 during the init sweep.
- correct_cnt  out  32  correct predictions (PRED_STATS_EN only).
- branch_cnt  out  32  trained branches (PRED_STATS_EN only).

Behaviour:
- Branch decode, applied to both Idata and Bdata: branch if [31:26]==6'b000001 (bal) or [31:28]==4'b0001 (bs).
- Indexing:
  - i_idx = Iadd[IDX_W+1:2] XOR {zero-pad, GHR}.
  - b_idx = Badd[IDX_W+1:2] XOR {zero-pad, GHR}.
  - Both use the current registered GHR.
- FSM states: INIT, RUN.
- rst_n low (async):
  - state=INIT, init_ptr=0, GHR=0, stats=0.
  - Outputs: ready=0, pred_valid=0, predict=0.
- INIT:
  - Each clk edge writes INIT_VAL to PHT[init_ptr] and increments init_ptr.
  - After writing entry ENTRY-1, go to RUN. Sweep takes exactly ENTRY cycles after rst_n deasserts.
  - All training inputs are ignored during INIT.
- RUN:
  - ready=1.
  - Prediction is combinational, zero latency: predict = MSB of PHT[i_idx] if Idata is a branch, else predict=0 and pred_valid=0. No tristate.
  - Training condition: Bdata is a branch AND if_id_write=1. On the next clk edge:
    - PHT[b_idx] saturating +1 if result=1 (hold at 2**CNT_W-1).
    - PHT[b_idx] saturating -1 if result=0 (hold at 0).
    - GHR <= {GHR[HIST_W-2:0], result}; for HIST_W=1, GHR <= result.
  - No training: PHT and GHR hold.
- Same-cycle read/update to the same index: predict reflects the pre-edge value. No bypass.
- b_idx uses the GHR value before that cycle's shift.
- Reset asserted mid-sweep or mid-run: immediate return to INIT, init_ptr=0, sweep restarts from 0.

Optional Feature:
- PRED_STATS_EN defined:
  - A training event (RUN state only) increments branch_cnt.
  - It also increments correct_cnt when MSB(PHT[b_idx] pre-update)==result.
  - Both counters are 32-bit, wrap on overflow, and async reset to 0.
- Not defined: correct_cnt and branch_cnt are tied to 0 and no counter registers are inferred.

Test Plan:
- Reset then release with default params → ready=0 for 128 cycles, ready=1 on cycle 128; every entry reads 2'b01; GHR=0.
- RUN, Idata=32'h0400_0000 (bal) at Iadd=32'h0000_0010 → pred_valid=1, predict=0. Idata=32'h0000_0000 → pred_valid=0, predict=0.
- Train bs at Badd=32'h0000_0020, result=1, four times with if_id_write=1:
  - Counter at each successive index saturates at 2'b11 where revisited.
  - GHR after the 4 updates = 6'b001111.
  - Same trains with if_id_write=0 → PHT and GHR unchanged.
- Alternating T/N/T/N on one branch with HIST_W=1 → two distinct indices used (Badd idx XOR 0, XOR 1). After warm-up, predict matches the pattern at each fetch.
- Assert rst_n low in RUN at init_ptr-independent time, and again mid-INIT at init_ptr=50 → ready drops asynchronously; full 128-cycle sweep restarts; stats cleared.
- PRED_STATS_EN defined: 10 trained branches, 7 matching pre-update MSB → branch_cnt=10, correct_cnt=7. Undefined → both read 0.

Source files
------------

// File: rtl/gshare_pre.sv
// gshare branch predictor: a pattern history table of saturating counters
// indexed by instruction address XOR global history. Prediction is combinational
// at fetch; training happens on the resolved branch. After reset an init sweep
// writes INIT_VAL into every entry before the block reports ready.
// Optional feature macro: PRED_STATS_EN (adds correct/trained branch counters).
module gshare_pre #(
    parameter int IDX_W    = 7,
    parameter int CNT_W    = 2,
    parameter int HIST_W   = 6,
    parameter int INIT_VAL = 2**(CNT_W-1)-1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Iadd,
    input  logic [31:0] Idata,
    input  logic [31:0] Badd,
    input  logic [31:0] Bdata,
    input  logic        result,
    input  logic        if_id_write,
    output logic        predict,
    output logic        pred_valid,
    output logic        ready,
    output logic [31:0] correct_cnt,
    output logic [31:0] branch_cnt
);

    localparam int               ENTRY   = 2**IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(INIT_VAL);

    typedef enum logic {INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
    logic [HIST_W-1:0]  ghr_q, ghr_d, ghr_shift;
    logic [CNT_W-1:0]   pht_q [ENTRY];

    logic [IDX_W-1:0]   ghr_ext, i_idx, b_idx;
    logic               train;
    logic               b_msb;

    // bal: opcode 000001; bs: top nibble 0001
    function automatic logic is_branch(input logic [31:0] w);
        return (w[31:26] == 6'b000001) || (w[31:28] == 4'b0001);
    endfunction

    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic up);
        if (up)
            return (c == CNT_MAX) ? c : c + CNT_W'(1);
        else
            return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    // Address bits outside the index field and non-opcode instruction bits are don't-care
    logic unused_bits;
    assign unused_bits = ^{Iadd[31:IDX_W+2], Iadd[1:0], Badd[31:IDX_W+2], Badd[1:0],
                           Idata[25:0], Bdata[25:0]};

    assign ghr_ext    = IDX_W'(ghr_q);
    assign i_idx      = Iadd[IDX_W+1:2] ^ ghr_ext;
    assign b_idx      = Badd[IDX_W+1:2] ^ ghr_ext;
    assign b_msb      = pht_q[b_idx][CNT_W-1];

    assign ready      = (state_q == RUN);
    assign pred_valid = ready && is_branch(Idata);
    assign predict    = pred_valid && pht_q[i_idx][CNT_W-1];
    assign train      = ready && is_branch(Bdata) && if_id_write;

    // History shift; a one-bit history simply becomes the latest outcome
    generate
        if (HIST_W == 1) begin : g_hist1
            assign ghr_shift = result;
        end else begin : g_histn
            assign ghr_shift = {ghr_q[HIST_W-2:0], result};
        end
    endgenerate

    // Next-state logic: sweep pointer through the table, then stay in RUN
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ghr_d      = ghr_q;
        case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + IDX_W'(1);
                if (init_ptr_q == IDX_W'(ENTRY-1))
                    state_d = RUN;
            end
            RUN: begin
                if (train)
                    ghr_d = ghr_shift;
            end
            default: state_d = INIT;
        endcase
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ghr_q      <= ghr_d;
        end
    end

    // Table storage: filled by the sweep, then trained; contents are not reset
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            pht_q[init_ptr_q] <= CNT_INI;
        else if (train)
            pht_q[b_idx] <= sat_step(pht_q[b_idx], result);
    end

`ifdef PRED_STATS_EN
    logic [31:0] correct_q, branch_q;

    // Accuracy counters: trained branches and those whose pre-update MSB matched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            correct_q <= '0;
            branch_q  <= '0;
        end else if (train) begin
            branch_q <= branch_q + 32'd1;
            if (b_msb == result)
                correct_q <= correct_q + 32'd1;
        end
    end

    assign correct_cnt = correct_q;
    assign branch_cnt  = branch_q;
`else
    logic unused_msb;
    assign unused_msb  = b_msb;
    assign correct_cnt = '0;
    assign branch_cnt  = '0;
`endif

endmodule

// File: tb/tb_gshare_pre.sv
// Directed bench for gshare_pre: default instance plus a HIST_W=1 instance.
module tb_gshare_pre;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Iadd, Idata, Badd, Bdata;
    logic        result, if_id_write;
    logic        predict, pred_valid, ready;
    logic [31:0] correct_cnt, branch_cnt;
    logic        predict1, pv1, ready1;
    logic [31:0] unused_cc1, unused_bc1;

    int nchk = 0;
    int nerr = 0;
    logic [5:0] ghr_m = '0;

    localparam logic [31:0] BS  = 32'h1000_0000;
    localparam logic [31:0] BAL = 32'h0400_0000;

    gshare_pre dut (
        .clk(clk), .rst_n(rst_n), .Iadd(Iadd), .Idata(Idata), .Badd(Badd), .Bdata(Bdata),
        .result(result), .if_id_write(if_id_write), .predict(predict),
        .pred_valid(pred_valid), .ready(ready), .correct_cnt(correct_cnt),
        .branch_cnt(branch_cnt)
    );

    gshare_pre #(.HIST_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Iadd(Iadd), .Idata(Idata), .Badd(Badd), .Bdata(Bdata),
        .result(result), .if_id_write(if_id_write), .predict(predict1),
        .pred_valid(pv1), .ready(ready1), .correct_cnt(unused_cc1),
        .branch_cnt(unused_bc1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train_addr(input logic [31:0] badd, input logic res, input logic we);
        Badd = badd; Bdata = BS; result = res; if_id_write = we;
        tick();
        if (we) ghr_m = {ghr_m[4:0], res};
        Bdata = '0; if_id_write = 1'b0;
    endtask

    // Train the table entry idx given the bench's view of the history
    task automatic train(input logic [6:0] idx, input logic res, input logic we);
        logic [6:0] a;
        a = idx ^ {1'b0, ghr_m};
        train_addr({23'd0, a, 2'b00}, res, we);
    endtask

    task automatic fetch(input logic [6:0] idx);
        logic [6:0] a;
        a = idx ^ {1'b0, ghr_m};
        Iadd = {23'd0, a, 2'b00}; Idata = BS;
        #1;
    endtask

    task automatic reset_sweep();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        repeat (128) tick();
        ghr_m = '0;
    endtask

    task automatic test_reset();
        Iadd = '0; Idata = BS; Badd = '0; Bdata = '0; result = 1'b0; if_id_write = 1'b0;
        rst_n = 1'b0;
        #1;
        nchk++; if (ready !== 1'b0) begin nerr++; $display("FAIL rst_ready: got %b want 0", ready); end
        nchk++; if (pred_valid !== 1'b0) begin nerr++; $display("FAIL rst_pv: got %b want 0", pred_valid); end
        nchk++; if (predict !== 1'b0) begin nerr++; $display("FAIL rst_predict: got %b want 0", predict); end
        tick(); #2; rst_n = 1'b1;
        repeat (127) tick();
        nchk++; if (ready !== 1'b0) begin nerr++; $display("FAIL sweep_127: ready got %b want 0", ready); end
        tick();
        nchk++; if (ready !== 1'b1) begin nerr++; $display("FAIL sweep_128: ready got %b want 1", ready); end
        nchk++; if (ready1 !== 1'b1) begin nerr++; $display("FAIL sweep_128_h1: ready got %b want 1", ready1); end
        ghr_m = '0;
        fetch(7'd0);
        nchk++; if ({pred_valid, predict} !== 2'b10) begin nerr++; $display("FAIL init_entry0: got %b want 10", {pred_valid, predict}); end
        // one taken step from weakly-not-taken flips the MSB
        train(7'd3, 1'b1, 1'b1);
        fetch(7'd3);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL init_inc: got %b want 1", predict); end
        fetch(7'd4);
        nchk++; if (predict !== 1'b0) begin nerr++; $display("FAIL init_other: got %b want 0", predict); end
    endtask

    task automatic test_predict();
        Iadd = 32'h0000_0010; Idata = BAL; #1;
        nchk++; if ({pred_valid, predict} !== 2'b10) begin nerr++; $display("FAIL bal_fetch: got %b want 10", {pred_valid, predict}); end
        Idata = 32'h0000_0000; #1;
        nchk++; if ({pred_valid, predict} !== 2'b00) begin nerr++; $display("FAIL nonbr_fetch: got %b want 00", {pred_valid, predict}); end
        fetch(7'd3); Idata = 32'h2000_0000; #1;
        nchk++; if ({pred_valid, predict} !== 2'b00) begin nerr++; $display("FAIL nonbr_trained: got %b want 00", {pred_valid, predict}); end
    endtask

    task automatic test_train();
        reset_sweep();
        repeat (4) train_addr(32'h0000_0020, 1'b1, 1'b1);
        nchk++; if (ghr_m !== 6'b001111) begin nerr++; $display("FAIL ghr_model: got %b want 001111", ghr_m); end
        fetch(7'd8);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL trained_8: got %b want 1", predict); end
        fetch(7'd9);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL trained_9: got %b want 1", predict); end
        fetch(7'd11);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL trained_11: got %b want 1", predict); end
        fetch(7'd15);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL trained_15: got %b want 1", predict); end
        fetch(7'd0);
        nchk++; if (predict !== 1'b0) begin nerr++; $display("FAIL untrained_0: got %b want 0", predict); end
    endtask

    task automatic test_saturation();
        // entry 8 holds 10: up to 11, held at 11, then two steps down
        repeat (2) train(7'd8, 1'b1, 1'b1);
        train(7'd8, 1'b0, 1'b1);
        fetch(7'd8);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL sat_hi_a: got %b want 1", predict); end
        train(7'd8, 1'b0, 1'b1);
        fetch(7'd8);
        nchk++; if (predict !== 1'b0) begin nerr++; $display("FAIL sat_hi_b: got %b want 0", predict); end
        // entry 40 from 01: down to 00, held, then two steps up
        repeat (3) train(7'd40, 1'b0, 1'b1);
        train(7'd40, 1'b1, 1'b1);
        fetch(7'd40);
        nchk++; if (predict !== 1'b0) begin nerr++; $display("FAIL sat_lo_a: got %b want 0", predict); end
        train(7'd40, 1'b1, 1'b1);
        fetch(7'd40);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL sat_lo_b: got %b want 1", predict); end
    endtask

    task automatic test_stall();
        logic [5:0] g0;
        g0 = ghr_m;
        repeat (3) train(7'd9, 1'b0, 1'b0);
        Badd = 32'h0000_0024; Bdata = 32'h2000_0000; result = 1'b0; if_id_write = 1'b1;
        tick();
        if_id_write = 1'b0;
        nchk++; if (ghr_m !== g0) begin nerr++; $display("FAIL stall_model: got %b want %b", ghr_m, g0); end
        fetch(7'd9);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL stall_hold: got %b want 1", predict); end
    endtask

    task automatic test_alt_hist1();
        logic p;
        reset_sweep();
        Iadd = 32'h0000_0020; Idata = BS;
        for (int k = 0; k < 10; k++) begin
            p = (k % 2 == 0);
            #1;
            if (k >= 4) begin
                nchk++;
                if ({pv1, predict1} !== {1'b1, p}) begin
                    nerr++; $display("FAIL alt_k%0d: got %b want %b", k, {pv1, predict1}, {1'b1, p});
                end
            end
            Badd = 32'h0000_0020; Bdata = BS; result = p; if_id_write = 1'b1;
            tick();
            Bdata = '0; if_id_write = 1'b0;
        end
    endtask

    task automatic test_reset_async();
        reset_sweep();
        repeat (2) train(7'd5, 1'b1, 1'b1);
        fetch(7'd5);
        nchk++; if (predict !== 1'b1) begin nerr++; $display("FAIL pre_rst_5: got %b want 1", predict); end
        rst_n = 1'b0; #1;
        nchk++; if (ready !== 1'b0) begin nerr++; $display("FAIL async_ready: got %b want 0", ready); end
        nchk++; if (branch_cnt !== 32'd0) begin nerr++; $display("FAIL async_stats: got %0d want 0", branch_cnt); end
        #1; rst_n = 1'b1;
        repeat (50) tick();
        rst_n = 1'b0; #1;
        nchk++; if (ready !== 1'b0) begin nerr++; $display("FAIL mid_init_ready: got %b want 0", ready); end
        #1; rst_n = 1'b1;
        repeat (127) tick();
        nchk++; if (ready !== 1'b0) begin nerr++; $display("FAIL resweep_127: got %b want 0", ready); end
        tick();
        nchk++; if (ready !== 1'b1) begin nerr++; $display("FAIL resweep_128: got %b want 1", ready); end
        ghr_m = '0;
        fetch(7'd5);
        nchk++; if (predict !== 1'b0) begin nerr++; $display("FAIL resweep_5: got %b want 0", predict); end
    endtask

    task automatic test_stats();
        logic [31:0] exp_b, exp_c;
        reset_sweep();
        nchk++; if ({branch_cnt, correct_cnt} !== 64'd0) begin nerr++; $display("FAIL stats_clr: got %0d/%0d want 0/0", correct_cnt, branch_cnt); end
        repeat (2) train(7'd20, 1'b1, 1'b1);
        train(7'd21, 1'b0, 1'b1);
        for (int e = 22; e < 27; e++) train(7'(e), 1'b0, 1'b1);
        train(7'd27, 1'b1, 1'b1);
        train(7'd28, 1'b1, 1'b1);
        train(7'd30, 1'b0, 1'b0);
`ifdef PRED_STATS_EN
        exp_b = 32'd10; exp_c = 32'd7;
`else
        exp_b = 32'd0;  exp_c = 32'd0;
`endif
        nchk++; if (branch_cnt !== exp_b) begin nerr++; $display("FAIL branch_cnt: got %0d want %0d", branch_cnt, exp_b); end
        nchk++; if (correct_cnt !== exp_c) begin nerr++; $display("FAIL correct_cnt: got %0d want %0d", correct_cnt, exp_c); end
    endtask

    initial begin
        test_reset();
        test_predict();
        test_train();
        test_saturation();
        test_stall();
        test_alt_hist1();
        test_reset_async();
        test_stats();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
